tia_horizontal_sync_counter: RTL and testbench
==============================================

# tia_horizontal_sync_counter

Horizontal timing core of the TIA: divides the colour clock into two non-overlapping phases (hphi1/hphi2), steps a 6-bit polynomial (LFSR) counter once per 4 colour clocks through 57 states (228 colour clocks per line), and decodes the horizontal event strobes (sync, colour burst, blank, line counter). It feeds the horizontal sync/blank logic and the object position counters.

## Interface
- No parameters.
- clk  in  1  colour clock; all state changes on its rising edge.
- rsyn  in  1  reset, asynchronous, active-high.
- hphi1  out  1  phase-1 clock, high 1 clk in 4.
- hphi2  out  1  phase-2 clock, high 1 clk in 4, never overlapping hphi1.
- rsynl  out  1  latched reset; high while the block is held in reset.
- out  out  6  LFSR counter state, out[5] = MSB.
- shb  out  1  start horizontal blank: out == 6'b010100 (count 56, last state of line).
- rsynd  out  1  delayed reset: high for the count period following a wrap from count 56.
- rhs  out  1  reset horizontal sync: out == 6'b110111 (count 8).
- cnt  out  1  centre / line counter: out == 6'b101100 (count 36).
- rcb  out  1  reset colour burst: out == 6'b001111 (count 12).
- shs  out  1  start horizontal sync: out == 6'b111100 (count 4).
- lrhb  out  1  late reset horizontal blank: out == 6'b010111 (count 18).
- rhb  out  1  reset horizontal blank: out == 6'b011100 (count 16).

## Operation
- Reset (rsyn high, async): phase p=0, hphi1=0, hphi2=0, out=000000, rsynd=0, rsynl=1.
- rsynl clears on the first clk rising edge with rsyn low; while rsynl=1 all other state holds its reset value.
- Phase counter p (2 bits) advances 0→1→2→3→0 each clk edge once rsynl=0; hphi1 registered high while p==1, hphi2 registered high while p==3; both low otherwise.
- LFSR update on the edge where p goes 3→0 (hphi2 falls): next = {~(out[0]^out[1]), out[5:1]}.
- Wrap: if out == 010100 (shb) at the update edge, next = 000000; rsynd <= 1 for the following count period, else rsynd <= 0.
- Lock-up guard: if out == 111111 at the update edge, next = 000000 (state unreachable from reset).
- Sequence from reset: 000000, 100000, 110000, 111000, 111100 (shs), 111110, 011111, 101111, 110111 (rhs), …, 001111 (rcb, count 12), …, 011100 (rhb, 16), 101110, 010111 (lrhb, 18), …, 101100 (cnt, 36), …, 010100 (shb, 56), 000000.
- Decoder outputs (shs, rhs, rcb, rhb, lrhb, cnt, shb) purely combinational from out; at most one high at a time; all others 0.

## Timing
- Period of hphi1/hphi2: 4 clk; line period: 57 counts = 228 clk.
- Edge E1 = first clk edge after the one clearing rsynl: hphi1 rises; out = count 0.
- out changes only at hphi2 falling edge, so it is stable across every hphi1 high pulse; k-th hphi1 pulse (k from 0) sees count k mod 57.
- Decodes valid from 1 time unit after out changes; no registered latency beyond the LFSR.
- Reset mid-line: asynchronous return to count 0 and all outputs to reset values; restart timing identical to power-on.

## Test plan
- Reset release, sample 1 ns after each hphi1 rise: counts 0..113 give shs only at 4/61, rhs only at 8/65, rcb only at 12/69, rhb only at 16/73, lrhb only at 18/75, cnt only at 36/93; all six decodes 0 elsewhere.
- Phase check over 16 clk: hphi1 and hphi2 each high exactly 1 clk in 4, never simultaneously, hphi2 two clks after hphi1.
- Sequence check: out steps 000000, 100000, 110000, 111000, 111100 at counts 0-4; 010100 at count 56 with shb=1, then 000000 with rsynd=1, rsynd=0 at count 1.
- Assert rsyn at count 30 for 3 clk: out=000000, hphi1=hphi2=0, rsynl=1 immediately; after release, first hphi1 sees count 0, shs at count 4.
- Force out to 111111 before an update edge: next count 000000, normal sequence resumes.

Source files
------------

// File: rtl/tia_horizontal_sync_counter.sv
// TIA horizontal timing core: two-phase clock divider, 57-state polynomial line
// counter advanced once per 4 colour clocks, and the horizontal event decodes.
module tia_horizontal_sync_counter (
  input  logic       clk,
  input  logic       rsyn,
  output logic       hphi1,
  output logic       hphi2,
  output logic       rsynl,
  output logic [5:0] out,
  output logic       shb,
  output logic       rsynd,
  output logic       rhs,
  output logic       cnt,
  output logic       rcb,
  output logic       shs,
  output logic       lrhb,
  output logic       rhb
);

  localparam logic [5:0] CNT_SHS  = 6'b111100;
  localparam logic [5:0] CNT_RHS  = 6'b110111;
  localparam logic [5:0] CNT_RCB  = 6'b001111;
  localparam logic [5:0] CNT_RHB  = 6'b011100;
  localparam logic [5:0] CNT_LRHB = 6'b010111;
  localparam logic [5:0] CNT_CNT  = 6'b101100;
  localparam logic [5:0] CNT_SHB  = 6'b010100;
  localparam logic [5:0] CNT_LOCK = 6'b111111;

  logic [1:0] phase_r;
  logic [5:0] out_r;
  logic [5:0] next_s;

  // One polynomial-counter step: XNOR feedback shifted in at the MSB.
  function automatic logic [5:0] lfsr_step(input logic [5:0] cur);
    lfsr_step = {~(cur[0] ^ cur[1]), cur[5:1]};
  endfunction

  // Next count: wrap after the last state of the line, escape the all-ones lock-up.
  always_comb begin
    next_s = 6'b000000;
    if (out_r == CNT_SHB) begin
      next_s = 6'b000000;
    end else if (out_r == CNT_LOCK) begin
      next_s = 6'b000000;
    end else begin
      next_s = lfsr_step(out_r);
    end
  end

  // Phase generator, line counter and reset latch; everything frozen while rsynl is set.
  always_ff @(posedge clk or posedge rsyn) begin
    if (rsyn) begin
      rsynl   <= 1'b1;
      phase_r <= 2'd0;
      hphi1   <= 1'b0;
      hphi2   <= 1'b0;
      out_r   <= 6'b000000;
      rsynd   <= 1'b0;
    end else if (rsynl) begin
      rsynl <= 1'b0;
    end else begin
      phase_r <= phase_r + 2'd1;
      hphi1   <= (phase_r == 2'd0);
      hphi2   <= (phase_r == 2'd2);
      // Count advances as hphi2 falls, so it is stable across every hphi1 pulse.
      if (phase_r == 2'd3) begin
        out_r <= next_s;
        rsynd <= (out_r == CNT_SHB);
      end
    end
  end

  assign out = out_r;

  // Event decodes straight off the counter state.
  always_comb begin
    shs  = 1'b0;
    rhs  = 1'b0;
    rcb  = 1'b0;
    rhb  = 1'b0;
    lrhb = 1'b0;
    cnt  = 1'b0;
    shb  = 1'b0;
    case (out_r)
      CNT_SHS:  shs  = 1'b1;
      CNT_RHS:  rhs  = 1'b1;
      CNT_RCB:  rcb  = 1'b1;
      CNT_RHB:  rhb  = 1'b1;
      CNT_LRHB: lrhb = 1'b1;
      CNT_CNT:  cnt  = 1'b1;
      CNT_SHB:  shb  = 1'b1;
      default: begin
        shs = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_tia_horizontal_sync_counter.sv
// Self-checking bench for tia_horizontal_sync_counter: line sequence, decodes,
// phase pattern, randomized mid-line resets and lock-up recovery.
module tb_tia_horizontal_sync_counter;

  logic       clk = 1'b0;
  logic       rsyn = 1'b1;
  logic       hphi1, hphi2, rsynl, shb, rsynd, rhs, cnt, rcb, shs, lrhb, rhb;
  logic [5:0] out;

  int n_checks = 0;
  int n_fail   = 0;
  logic [5:0] seq [0:56];

  tia_horizontal_sync_counter dut (
    .clk(clk), .rsyn(rsyn), .hphi1(hphi1), .hphi2(hphi2), .rsynl(rsynl),
    .out(out), .shb(shb), .rsynd(rsynd), .rhs(rhs), .cnt(cnt), .rcb(rcb),
    .shs(shs), .lrhb(lrhb), .rhb(rhb)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  // Advance to the next sample point 1 ns after an hphi1 rise, bounded.
  task automatic next_hphi1();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (hphi1 === 1'b1) ok = 1'b1;
    end
    if (!ok) chk("hphi1_timeout", 6'd0, 6'd1);
  endtask

  // Expected outputs for the hphi1 pulse that sees line position k.
  task automatic check_count(input int k, input logic exp_rsynd);
    int c;
    c = k % 57;
    chk("out",   out,              seq[c]);
    chk("shs",   {5'd0, shs},      {5'd0, c == 4});
    chk("rhs",   {5'd0, rhs},      {5'd0, c == 8});
    chk("rcb",   {5'd0, rcb},      {5'd0, c == 12});
    chk("rhb",   {5'd0, rhb},      {5'd0, c == 16});
    chk("lrhb",  {5'd0, lrhb},     {5'd0, c == 18});
    chk("cnt",   {5'd0, cnt},      {5'd0, c == 36});
    chk("shb",   {5'd0, shb},      {5'd0, c == 56});
    chk("rsynd", {5'd0, rsynd},    {5'd0, exp_rsynd});
    chk("hphi2_at_hphi1", {5'd0, hphi2}, 6'd0);
  endtask

  task automatic do_reset(input int ncyc);
    @(negedge clk);
    rsyn = 1'b1;
    #1;
    chk("rst_rsynl", {5'd0, rsynl}, 6'd1);
    chk("rst_out",   out,           6'd0);
    chk("rst_hphi1", {5'd0, hphi1}, 6'd0);
    chk("rst_hphi2", {5'd0, hphi2}, 6'd0);
    chk("rst_rsynd", {5'd0, rsynd}, 6'd0);
    repeat (ncyc) @(negedge clk);
    rsyn = 1'b0;
  endtask

  initial begin
    logic [5:0] v;
    int pos, dur;

    // Reference line: iterate the feedback rule from zero; position 56 wraps to 0.
    v = 6'd0;
    for (int k = 0; k < 57; k++) begin
      seq[k] = v;
      v = {~(v[0] ^ v[1]), v[5:1]};
    end

    #12;
    chk("por_rsynl", {5'd0, rsynl}, 6'd1);
    chk("por_out",   out,           6'd0);
    chk("por_hphi",  {4'd0, hphi1, hphi2}, 6'd0);
    @(negedge clk);
    rsyn = 1'b0;

    // Two full lines from reset release.
    for (int k = 0; k < 114; k++) begin
      next_hphi1();
      check_count(k, k == 57);
    end
    chk("seq0", seq[0], 6'b000000);

    // Phase pattern over 16 clocks starting on an hphi1 pulse.
    for (int i = 0; i < 16; i++) begin
      chk("ph_hphi1", {5'd0, hphi1}, {5'd0, (i % 4) == 0});
      chk("ph_hphi2", {5'd0, hphi2}, {5'd0, (i % 4) == 2});
      @(posedge clk);
      #1;
    end

    do_reset(2);
    // Mid-line resets: the fixed case first, then randomized position/length.
    for (int it = 0; it < 4; it++) begin
      pos = (it == 0) ? 30 : int'($urandom_range(0, 56));
      dur = (it == 0) ? 3  : int'($urandom_range(1, 5));
      for (int k = 0; k <= pos; k++) begin
        next_hphi1();
        check_count(k, 1'b0);
      end
      do_reset(dur);
    end
    for (int k = 0; k <= 4; k++) begin
      next_hphi1();
      check_count(k, 1'b0);
    end

    // Lock-up recovery: plant all-ones before the next update edge.
    do_reset(1);
    for (int k = 0; k <= 2; k++) begin
      next_hphi1();
      check_count(k, 1'b0);
    end
    force dut.out_r = 6'b111111;
    #1;
    release dut.out_r;
    #1;
    chk("lock_out", out, 6'b111111);
    chk("lock_dec", {shs, rhs, rcb, rhb, lrhb, cnt}, 6'd0);
    chk("lock_shb", {5'd0, shb}, 6'd0);
    for (int k = 0; k <= 5; k++) begin
      next_hphi1();
      check_count(k, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
